// File: rtl/cache_pkg.sv
// ----------------------------------------------------------------------------
// cache_pkg
//   Definitions shared by the cache controller, its word counter and the
//   cache array (cache_memory).
//
//   Contents:
//     - default widths for the address, tag, data word and line geometry
//     - cache_state_e : controller sequencing states
//     - addr_tag / addr_index / addr_offset : address field extraction
//
//   Address layout (default widths):
//     [31:13] tag   [12:6] set index   [5:0] line offset
//   Only the low $clog2(CACHE_BLOCK_WORDS) offset bits select a word.
// ----------------------------------------------------------------------------
package cache_pkg;

    localparam int unsigned CACHE_ADDR_W      = 32;
    localparam int unsigned CACHE_TAG_W       = 19;
    localparam int unsigned CACHE_WORD_W      = 8;
    localparam int unsigned CACHE_BLOCK_WORDS = 8;
    localparam int unsigned CACHE_OFFSET_BITS = 6;
    localparam int unsigned CACHE_INDEX_BITS  = CACHE_ADDR_W - CACHE_TAG_W - CACHE_OFFSET_BITS;

    localparam int unsigned CACHE_INDEX_LSB   = CACHE_OFFSET_BITS;
    localparam int unsigned CACHE_TAG_LSB     = CACHE_OFFSET_BITS + CACHE_INDEX_BITS;

    typedef enum logic [2:0] {
        IDLE,
        LOOKUP,
        RESPOND,
        WB,
        FILL
    } cache_state_e;

    function automatic logic [CACHE_TAG_W-1:0] addr_tag(input logic [CACHE_ADDR_W-1:0] addr);
        return addr[CACHE_ADDR_W-1:CACHE_TAG_LSB];
    endfunction

    function automatic logic [CACHE_INDEX_BITS-1:0] addr_index(input logic [CACHE_ADDR_W-1:0] addr);
        return addr[CACHE_TAG_LSB-1:CACHE_INDEX_LSB];
    endfunction

    function automatic logic [CACHE_OFFSET_BITS-1:0] addr_offset(input logic [CACHE_ADDR_W-1:0] addr);
        return addr[CACHE_OFFSET_BITS-1:0];
    endfunction

endpackage

// File: rtl/cache_word_counter.sv
// ----------------------------------------------------------------------------
// cache_word_counter
//   Word offset counter shared by the write-back and line-fill loops.
//
//   Ports:
//     clk       in   clock, rising edge
//     rst_b     in   asynchronous active-low reset
//     inc       in   advance to the next word
//     clr       in   return to word 0 (wins over inc)
//     word_cnt  out  current word offset within the line
//     last      out  word_cnt is the final word of the line
// ----------------------------------------------------------------------------
module cache_word_counter #(
    parameter int unsigned BLOCK_SIZE = 8,
    parameter int unsigned CNT_W      = $clog2(BLOCK_SIZE)
) (
    input  logic             clk,
    input  logic             rst_b,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] word_cnt,
    output logic             last
);

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            word_cnt <= '0;
        end else if (clr) begin
            word_cnt <= '0;
        end else if (inc) begin
            word_cnt <= word_cnt + 1'b1;
        end
    end

    assign last = (word_cnt == CNT_W'(BLOCK_SIZE - 1));

endmodule

// File: rtl/cache_controller.sv
// ----------------------------------------------------------------------------
// cache_controller
//   Sequencing FSM between the CPU port, the 4-way set-associative cache
//   array and a word-serial main-memory port. One CPU request is serviced at
//   a time: lookup, optional write-back of a dirty victim, line fill, then a
//   replay lookup that completes the access as a normal hit.
//
//   Ports:
//     clk, rst_b                        clock (rising edge), async active-low reset
//     cpu_req/cpu_we/cpu_addr/cpu_wdata CPU request, held until cpu_ready
//     cpu_rdata/cpu_ready               read data and one-cycle completion pulse
//     cache_addr/cache_try_read         array address and lookup strobe
//     cache_try_write                   CPU write-hit strobe
//     cache_write/cache_wdata           fill-word write strobe and data
//     cache_data_out/cache_hit          array read data and hit indication
//     cache_dirty/cache_victim_tag      victim state of the indexed set
//     mem_req/mem_we/mem_addr/mem_wdata memory word request
//     mem_rdata/mem_ack                 memory word response
//
//   Optional build macro CACHE_CTRL_PERF_EN adds hit_count / miss_count
//   (16-bit saturating counts of first-lookup hits and misses).
// ----------------------------------------------------------------------------
module cache_controller
    import cache_pkg::*;
#(
    parameter int unsigned ADDRESS_WORD_SIZE = CACHE_ADDR_W,
    parameter int unsigned TAG_SIZE          = CACHE_TAG_W,
    parameter int unsigned WORD_SIZE         = CACHE_WORD_W,
    parameter int unsigned BLOCK_SIZE        = CACHE_BLOCK_WORDS,
    parameter int unsigned OFFSET_BITS       = CACHE_OFFSET_BITS
) (
    input  logic                         clk,
    input  logic                         rst_b,

    input  logic                         cpu_req,
    input  logic                         cpu_we,
    input  logic [ADDRESS_WORD_SIZE-1:0] cpu_addr,
    input  logic [WORD_SIZE-1:0]         cpu_wdata,
    output logic [WORD_SIZE-1:0]         cpu_rdata,
    output logic                         cpu_ready,

    output logic [ADDRESS_WORD_SIZE-1:0] cache_addr,
    output logic                         cache_try_read,
    output logic                         cache_try_write,
    output logic                         cache_write,
    output logic [WORD_SIZE-1:0]         cache_wdata,
    input  logic [WORD_SIZE-1:0]         cache_data_out,
    input  logic                         cache_hit,
    input  logic                         cache_dirty,
    input  logic [TAG_SIZE-1:0]          cache_victim_tag,

    output logic                         mem_req,
    output logic                         mem_we,
    output logic [ADDRESS_WORD_SIZE-1:0] mem_addr,
    output logic [WORD_SIZE-1:0]         mem_wdata,
    input  logic [WORD_SIZE-1:0]         mem_rdata,
    input  logic                         mem_ack
`ifdef CACHE_CTRL_PERF_EN
    ,
    output logic [15:0]                  hit_count,
    output logic [15:0]                  miss_count
`endif
);

    localparam int unsigned CNT_W      = $clog2(BLOCK_SIZE);
    localparam int unsigned INDEX_BITS = ADDRESS_WORD_SIZE - TAG_SIZE - OFFSET_BITS;

    cache_state_e state, next_state;

    // Latched CPU request and victim tag
    logic [ADDRESS_WORD_SIZE-1:0] req_addr;
    logic                         req_we;
    logic [WORD_SIZE-1:0]         req_wdata;
    logic [TAG_SIZE-1:0]          victim_tag;
    logic                         replay;

    logic                         cnt_inc;
    logic                         cnt_clr;
    logic [CNT_W-1:0]             word_cnt;
    logic                         word_last;

    logic [TAG_SIZE-1:0]          req_tag;
    logic [INDEX_BITS-1:0]        req_index;
    logic [OFFSET_BITS-1:0]       word_off;
    logic [ADDRESS_WORD_SIZE-1:0] wb_addr;
    logic [ADDRESS_WORD_SIZE-1:0] fill_addr;

    cache_word_counter #(
        .BLOCK_SIZE (BLOCK_SIZE),
        .CNT_W      (CNT_W)
    ) u_word_counter (
        .clk      (clk),
        .rst_b    (rst_b),
        .inc      (cnt_inc),
        .clr      (cnt_clr),
        .word_cnt (word_cnt),
        .last     (word_last)
    );

    assign req_tag   = req_addr[ADDRESS_WORD_SIZE-1 -: TAG_SIZE];
    assign req_index = req_addr[OFFSET_BITS +: INDEX_BITS];
    // Word counter sits in the low offset bits; upper offset bits stay zero
    assign word_off  = OFFSET_BITS'(word_cnt);
    assign wb_addr   = {victim_tag, req_index, word_off};
    assign fill_addr = {req_tag, req_index, word_off};

    // ------------------------------------------------------------------
    // State and request registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state      <= IDLE;
            req_addr   <= '0;
            req_we     <= 1'b0;
            req_wdata  <= '0;
            victim_tag <= '0;
            replay     <= 1'b0;
            cpu_rdata  <= '0;
        end else begin
            state <= next_state;

            if (state == IDLE && cpu_req) begin
                req_addr  <= cpu_addr;
                req_we    <= cpu_we;
                req_wdata <= cpu_wdata;
                replay    <= 1'b0;
            end

            // LOOKUP lasts one cycle, so this captures the tag on exit
            if (state == LOOKUP) begin
                victim_tag <= cache_victim_tag;
                if (cache_hit) begin
                    cpu_rdata <= cache_data_out;
                end
            end

            if (state == FILL && next_state == LOOKUP) begin
                replay <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Next state and outputs
    // ------------------------------------------------------------------
    always_comb begin
        next_state      = state;
        cnt_inc         = 1'b0;
        cnt_clr         = 1'b0;
        cpu_ready       = 1'b0;
        cache_addr      = '0;
        cache_try_read  = 1'b0;
        cache_try_write = 1'b0;
        cache_write     = 1'b0;
        cache_wdata     = '0;
        mem_req         = 1'b0;
        mem_we          = 1'b0;
        mem_addr        = '0;
        mem_wdata       = '0;

        case (state)
            IDLE: begin
                if (cpu_req) begin
                    next_state = LOOKUP;
                end
            end

            LOOKUP: begin
                cache_addr     = req_addr;
                cache_try_read = 1'b1;
                if (req_we) begin
                    cache_try_write = 1'b1;
                    cache_wdata     = req_wdata;
                end
                if (cache_hit) begin
                    next_state = RESPOND;
                end else if (cache_dirty) begin
                    next_state = WB;
                end else begin
                    next_state = FILL;
                end
            end

            RESPOND: begin
                cpu_ready  = 1'b1;
                next_state = IDLE;
            end

            WB: begin
                cache_addr     = wb_addr;
                cache_try_read = 1'b1;
                mem_req        = 1'b1;
                mem_we         = 1'b1;
                mem_addr       = wb_addr;
                mem_wdata      = cache_data_out;
                if (mem_ack) begin
                    if (word_last) begin
                        cnt_clr    = 1'b1;
                        next_state = FILL;
                    end else begin
                        cnt_inc = 1'b1;
                    end
                end
            end

            FILL: begin
                mem_req  = 1'b1;
                mem_addr = fill_addr;
                if (mem_ack) begin
                    cache_write = 1'b1;
                    cache_addr  = fill_addr;
                    cache_wdata = mem_rdata;
                    if (word_last) begin
                        cnt_clr    = 1'b1;
                        next_state = LOOKUP;
                    end else begin
                        cnt_inc = 1'b1;
                    end
                end
            end

            default: begin
                next_state = IDLE;
            end
        endcase
    end

`ifdef CACHE_CTRL_PERF_EN
    // ------------------------------------------------------------------
    // Saturating hit/miss counters; replay lookups are not counted
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            hit_count  <= '0;
            miss_count <= '0;
        end else if (state == LOOKUP && !replay) begin
            if (cache_hit) begin
                if (hit_count != '1) begin
                    hit_count <= hit_count + 16'd1;
                end
            end else begin
                if (miss_count != '1) begin
                    miss_count <= miss_count + 16'd1;
                end
            end
        end
    end
`endif

endmodule

// File: doc/cache_controller.md
Name: cache_controller

Overview:
- Sequencing FSM between the CPU port, the 4-way set-associative cache array (`cache_memory`), and a word-serial main-memory port.
- Performs the hit/miss lookup and write-back of dirty victims.
- Performs the line fill and a replay lookup that completes the CPU access.
- One outstanding CPU request at a time.

Parameters:
- ADDRESS_WORD_SIZE, 32, CPU/memory address width
- TAG_SIZE, 19, tag field addr[31:13]
- WORD_SIZE, 8, data word width
- BLOCK_SIZE, 8, words per line; offset counter width = $clog2(BLOCK_SIZE)
- OFFSET_BITS, 6, line offset field addr[5:0]; index is addr[12:6]

Ports:
- clk  in  1  clock, rising edge
- rst_b  in  1  asynchronous active-low reset
- cpu_req  in  1  request; held high until cpu_ready
- cpu_we  in  1  1=write, 0=read
- cpu_addr  in  ADDRESS_WORD_SIZE  access address
- cpu_wdata  in  WORD_SIZE  write data
- cpu_rdata  out  WORD_SIZE  read data, valid with cpu_ready
- cpu_ready  out  1  one-cycle completion pulse
- cache_addr  out  ADDRESS_WORD_SIZE  address to cache array
- cache_try_read  out  1  lookup/read strobe
- cache_try_write  out  1  CPU write-hit strobe (sets dirty)
- cache_write  out  1  fill-word write strobe
- cache_wdata  out  WORD_SIZE  data to cache array
- cache_data_out  in  WORD_SIZE  cache read data
- cache_hit  in  1  combinational hit for cache_addr
- cache_dirty  in  1  victim line of indexed set is dirty
- cache_victim_tag  in  TAG_SIZE  tag of the victim way selected by the array
- mem_req  out  1  memory word request; held until mem_ack
- mem_we  out  1  1=write-back word, 0=fill read
- mem_addr  out  ADDRESS_WORD_SIZE  memory word address
- mem_wdata  out  WORD_SIZE  write-back data
- mem_rdata  in  WORD_SIZE  fill data, valid with mem_ack
- mem_ack  in  1  one-cycle word acknowledge

Behaviour:
- Reset (async, rst_b=0):
  - State IDLE; word_cnt=0.
  - All outputs 0, including cpu_rdata, mem_addr and cache_addr.
  - Any memory transaction in flight is abandoned.
- The CPU request (addr, we, wdata) is latched on leaving IDLE. Later CPU input changes are ignored until cpu_ready.
- IDLE: cpu_req=1 -> LOOKUP.
- LOOKUP:
  - Drive cache_addr=latched addr and cache_try_read=1.
  - Write requests additionally drive cache_try_write=1 and cache_wdata=wdata.
  - If cache_hit: capture cache_data_out into cpu_rdata -> RESPOND.
  - If miss and cache_dirty: -> WB.
  - If miss and clean: -> FILL.
- RESPOND: cpu_ready=1 for exactly one cycle -> IDLE.
  - Hit latency: cpu_req sampled at edge N, cpu_ready high in cycle N+2.
- WB (one pass per word):
  - Drive cache_addr={cache_victim_tag, index, word_cnt} with cache_try_read=1.
  - Drive mem_req=1, mem_we=1, mem_addr=same address, mem_wdata=cache_data_out.
  - On mem_ack: word_cnt++. On the ack for word BLOCK_SIZE-1: word_cnt=0 -> FILL.
- FILL (one pass per word):
  - Drive mem_req=1, mem_we=0, mem_addr={tag, index, word_cnt}.
  - On mem_ack: for that cycle drive cache_write=1, cache_addr=mem_addr and cache_wdata=mem_rdata; word_cnt++.
  - On the last word: word_cnt=0 -> LOOKUP (replay). The replay must hit and completes as a normal hit.
- word_cnt occupies the low $clog2(BLOCK_SIZE) bits of the offset field; upper offset bits are 0. word_cnt wraps to 0 only at the state exit.
- mem_req stays high across consecutive words. mem_ack with mem_req=0 is ignored.
- The victim tag is sampled on LOOKUP exit. The victim address does not change during WB.
- cpu_req deasserted mid-transaction is a protocol violation: the controller completes the transaction and still pulses cpu_ready.
- Replay miss (array fault) re-enters the miss path; there is no deadlock guard.

Optional Feature:
- Macro: CACHE_CTRL_PERF_EN.
- When defined, adds two outputs:
  - hit_count[15:0]: increments on a first-LOOKUP hit.
  - miss_count[15:0]: increments on a first-LOOKUP miss.
  - Replays do not count. Both counters saturate at 16'hFFFF and reset to 0.
- When undefined, neither port nor counter logic exists.

Decomposition:
- Shared package `cache_pkg`:
  - State enum (IDLE, LOOKUP, RESPOND, WB, FILL).
  - Address field helpers for tag, index and offset bit positions.
  - Default widths shared with `cache_memory`.
- One natural sub-module, `cache_word_counter`: offset counter with inc/clear and a last-word flag, shared by the WB and FILL loops.

Test Plan:
- Read hit: line preloaded at 0x0000_1040 with word 0xA5; cpu_req read -> cpu_ready at cycle N+2, cpu_rdata=0xA5, mem_req never asserted.
- Clean read miss: read 0x0000_2080, mem returns 0x10..0x17 with 1-cycle ack latency -> 8 mem reads at 0x2080..0x2087, replay hit, cpu_rdata=0x10, cpu_ready once.
- Dirty eviction: dirty victim tag 0x00001 at index 2 with data 0x20..0x27; request to a new tag -> 8 mem writes at 0x0000_2080..0x2087 with data 0x20..0x27, then 8 fill reads, then cpu_ready.
- Write hit: write 0x5A to a resident address -> cache_try_write=1 for one cycle; a subsequent read returns 0x5A and cache_dirty=1.
- Reset mid-FILL: rst_b low after the 3rd mem_ack -> mem_req=0, cpu_ready=0 and state IDLE immediately; a fresh request after release completes correctly.
- Perf (CACHE_CTRL_PERF_EN): 3 hits and 2 misses -> hit_count=3, miss_count=2 (replays not counted).
